// File: rtl/pwm_duty_meter_if.sv
// Measurement bus of the PWM duty meter: the PWM waveform in, period/high/duty results out.
// The master side drives the waveform and consumes the results; the meter is the slave.
interface pwm_duty_meter_if #(
    parameter int CNT_W = 16
);
    logic             PWM_IN;
    logic [7:0]       DUTY_OUT;
    logic [CNT_W-1:0] PERIOD_OUT;
    logic [CNT_W-1:0] HIGH_OUT;
    logic             VALID;
    logic             STUCK;

    modport master (
        output PWM_IN,
        input  DUTY_OUT,
        input  PERIOD_OUT,
        input  HIGH_OUT,
        input  VALID,
        input  STUCK
    );

    modport slave (
        input  PWM_IN,
        output DUTY_OUT,
        output PERIOD_OUT,
        output HIGH_OUT,
        output VALID,
        output STUCK
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// Rising-edge to rising-edge PWM meter: period and high-time counters, stuck timeout,
// and an 8-iteration restoring divider producing floor(100*HIGH/PERIOD).
module pwm_duty_meter #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pwm_duty_meter_if.slave   bus
);

    localparam int               NW        = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [NW-1:0]    PCT_SCALE = NW'(100);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Returns {new remainder, quotient bit} for one restoring step against p<<k.
    function automatic logic [NW:0] div_step(input logic [NW-1:0]    rem,
                                             input logic [CNT_W-1:0] p,
                                             input logic [2:0]       k);
        logic [NW:0] sub;
        sub = {8'd0, p} << k;
        if ({1'b0, rem} >= sub) begin
            return {rem - sub[NW-1:0], 1'b1};
        end
        return {rem, 1'b0};
    endfunction

    state_t           state;
    state_t           state_nxt;

    logic             meta_p0;
    logic             s_p1;
    logic             s_d_p2;
    logic             rise;

    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             stuck;
    logic             capture;
    logic             timeout;

    logic             div_run;
    logic             div_fin;
    logic             div_busy;
    logic [2:0]       div_k;
    logic [NW-1:0]    div_rem;
    logic [CNT_W-1:0] div_p;
    logic [CNT_W-1:0] div_h;
    logic [7:0]       div_q;
    logic [NW:0]      div_nxt;

    logic [7:0]       duty_p3;
    logic [CNT_W-1:0] period_p3;
    logic [CNT_W-1:0] high_p3;
    logic             vld_p3;

    // Stage p0/p1: two-flop synchronizer; p2: edge register
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            s_p1    <= 1'b0;
            s_d_p2  <= 1'b0;
        end else begin
            meta_p0 <= bus.PWM_IN;
            s_p1    <= meta_p0;
            s_d_p2  <= s_p1;
        end
    end

    assign rise     = s_p1 & ~s_d_p2;
    assign div_busy = div_run | div_fin;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise always wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (!stuck && period_cnt == CNT_MAX) begin
                    timeout = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = ~div_busy;
                end else if (period_cnt == CNT_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters restart at 1 on every rise; in IDLE they only time the post-reset wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            stuck      <= 1'b0;
        end else if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            stuck      <= 1'b0;
        end else if (timeout) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            stuck      <= 1'b1;
        end else if (state == MEASURE) begin
            period_cnt <= sat_inc(period_cnt);
            if (s_p1) begin
                high_cnt <= sat_inc(high_cnt);
            end
        end else if (!stuck) begin
            period_cnt <= sat_inc(period_cnt);
        end
    end

    assign div_nxt = div_step(div_rem, div_p, div_k);

    // Divider: load on capture, one quotient bit per cycle MSB first; div_fin keeps
    // the divider busy through the cycle its result is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_run <= 1'b0;
            div_fin <= 1'b0;
            div_k   <= '0;
            div_rem <= '0;
            div_p   <= '0;
            div_h   <= '0;
            div_q   <= '0;
        end else begin
            div_fin <= 1'b0;
            if (capture) begin
                div_run <= 1'b1;
                div_k   <= 3'd7;
                div_rem <= NW'(high_cnt) * PCT_SCALE;
                div_p   <= period_cnt;
                div_h   <= high_cnt;
                div_q   <= '0;
            end else if (div_run) begin
                div_rem <= div_nxt[NW:1];
                div_q   <= {div_q[6:0], div_nxt[0]};
                div_k   <= div_k - 3'd1;
                if (div_k == 3'd0) begin
                    div_run <= 1'b0;
                    div_fin <= 1'b1;
                end
            end
        end
    end

    // Stage p3: result registers, held between VALID pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_p3   <= '0;
            period_p3 <= '0;
            high_p3   <= '0;
            vld_p3    <= 1'b0;
        end else begin
            vld_p3 <= 1'b0;
            if (div_run && div_k == 3'd0) begin
                duty_p3   <= {div_q[6:0], div_nxt[0]};
                period_p3 <= div_p;
                high_p3   <= div_h;
                vld_p3    <= 1'b1;
            end else if (timeout && !div_busy) begin
                duty_p3   <= s_p1 ? 8'd100 : 8'd0;
                period_p3 <= '0;
                high_p3   <= '0;
                vld_p3    <= 1'b1;
            end
        end
    end

    assign bus.DUTY_OUT   = duty_p3;
    assign bus.PERIOD_OUT = period_p3;
    assign bus.HIGH_OUT   = high_p3;
    assign bus.VALID      = vld_p3;
    assign bus.STUCK      = stuck;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: per-cycle PWM stimulus is recorded with the DUT outputs and
// checked against an event-level model, a table of known duty results and hand sequences.
module tb_pwm_duty_meter;
  localparam int CNT_W = 10;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int MAXC  = 2200;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();
  pwm_duty_meter #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit v[MAXC];
  bit rv[MAXC];
  bit rec_v[MAXC];
  bit rec_s[MAXC];
  int rec_d[MAXC];
  int rec_p[MAXC];
  int rec_h[MAXC];
  bit ex_st[MAXC];
  bit ev_v[MAXC+16];
  int ev_d[MAXC+16];
  int ev_p[MAXC+16];
  int ev_h[MAXC+16];

  typedef struct {
    int period;
    int high;
    int nper;
    int exp_duty;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      v[i]  = 1'b0;
      rv[i] = 1'b0;
    end
  endtask

  task automatic add_pwm(inout int pos, input int per, input int hi, input int cnt);
    for (int p = 0; p < cnt; p++) begin
      for (int k = 0; k < per; k++) begin
        if (pos < MAXC) v[pos] = (k < hi);
        pos++;
      end
    end
  endtask

  // Reset, then drive v[] / rv[] one value per cycle and record outputs mid-cycle.
  task automatic run_seg(input int n);
    reset = 1'b1;
    bus.PWM_IN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      reset = rv[c];
      bus.PWM_IN = v[c];
      @(negedge clk);
      rec_v[c] = bus.VALID;
      rec_s[c] = bus.STUCK;
      rec_d[c] = int'(bus.DUTY_OUT);
      rec_p[c] = int'(bus.PERIOD_OUT);
      rec_h[c] = int'(bus.HIGH_OUT);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Synchronized level seen by the meter in cycle c: the input two cycles earlier,
  // forced low while the synchronizer refills after a reset.
  function automatic bit sv(input int c, input int base);
    if (c - 2 >= base && c - 2 >= 0) return v[c-2];
    return 1'b0;
  endfunction

  // Event model: rises, captures (10-cycle divider occupancy), stuck timeouts, resets.
  task automatic run_model(input int n);
    int base, last, busy_until, hsum;
    bit meas, st, r;
    base = 0; last = 0; busy_until = 0; meas = 1'b0; st = 1'b0;
    for (int j = 0; j < MAXC + 16; j++) begin
      ev_v[j] = 1'b0; ev_d[j] = 0; ev_p[j] = 0; ev_h[j] = 0;
    end
    for (int c = 0; c < n; c++) begin
      ex_st[c] = st;
      if (rv[c]) begin
        for (int j = c + 1; j < MAXC + 16; j++) ev_v[j] = 1'b0;
        base = c + 1; last = c + 1; busy_until = 0; meas = 1'b0; st = 1'b0;
      end else begin
        r = sv(c, base) && !sv(c - 1, base);
        if (r) begin
          if (meas && c >= busy_until) begin
            hsum = 0;
            for (int k = last; k < c; k++) hsum += int'(sv(k, base));
            ev_v[c+9] = 1'b1;
            ev_p[c+9] = c - last;
            ev_h[c+9] = hsum;
            ev_d[c+9] = (100 * hsum) / (c - last);
            busy_until = c + 10;
          end
          meas = 1'b1; last = c; st = 1'b0;
        end else if (!st && c - last == MAXV) begin
          st = 1'b1; meas = 1'b0;
          if (c >= busy_until) begin
            ev_v[c+1] = 1'b1;
            ev_d[c+1] = sv(c, base) ? 100 : 0;
            ev_p[c+1] = 0;
            ev_h[c+1] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_model(input int n, input string tag);
    int cd, cp, ch;
    cd = 0; cp = 0; ch = 0;
    for (int c = 0; c < n; c++) begin
      if (c > 0 && rv[c-1]) begin
        cd = 0; cp = 0; ch = 0;
      end
      if (ev_v[c]) begin
        cd = ev_d[c]; cp = ev_p[c]; ch = ev_h[c];
      end
      check($sformatf("%s valid@%0d", tag, c), int'(rec_v[c]), int'(ev_v[c]));
      check($sformatf("%s stuck@%0d", tag, c), int'(rec_s[c]), int'(ex_st[c]));
      if (ev_v[c] || c == 0 || c == n - 1 || (c > 0 && rv[c-1])) begin
        check($sformatf("%s duty@%0d", tag, c), rec_d[c], cd);
        check($sformatf("%s period@%0d", tag, c), rec_p[c], cp);
        check($sformatf("%s high@%0d", tag, c), rec_h[c], ch);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos, n, nv, per, hi;
    bus.PWM_IN = 1'b0;

    tbl[0] = '{period: 100, high: 30,  nper: 5,  exp_duty: 30, exp_period: 100, exp_high: 30};
    tbl[1] = '{period: 50,  high: 26,  nper: 6,  exp_duty: 52, exp_period: 50,  exp_high: 26};
    tbl[2] = '{period: 3,   high: 1,   nper: 20, exp_duty: 33, exp_period: 3,   exp_high: 1};
    tbl[3] = '{period: 5,   high: 2,   nper: 30, exp_duty: 40, exp_period: 5,   exp_high: 2};
    tbl[4] = '{period: 7,   high: 6,   nper: 20, exp_duty: 85, exp_period: 7,   exp_high: 6};
    tbl[5] = '{period: 255, high: 254, nper: 4,  exp_duty: 99, exp_period: 255, exp_high: 254};
    tbl[6] = '{period: 2,   high: 1,   nper: 40, exp_duty: 50, exp_period: 2,   exp_high: 1};

    for (int t = 0; t < 7; t++) begin
      clear_stim();
      pos = 4;
      add_pwm(pos, tbl[t].period, tbl[t].high, tbl[t].nper);
      n = pos + 30;
      run_seg(n);
      run_model(n);
      compare_model(n, $sformatf("tbl%0d", t));
      nv = 0;
      for (int c = 0; c < n; c++) begin
        if (rec_v[c]) begin
          nv++;
          check($sformatf("tbl%0d duty", t), rec_d[c], tbl[t].exp_duty);
          check($sformatf("tbl%0d period", t), rec_p[c], tbl[t].exp_period);
          check($sformatf("tbl%0d high", t), rec_h[c], tbl[t].exp_high);
        end
      end
      check($sformatf("tbl%0d any_valid", t), int'(nv > 0), 1);
    end

    // First VALID for period 100 comes 9 cycles after the second rise (rise at 6, 106).
    clear_stim();
    pos = 4;
    add_pwm(pos, 100, 30, 3);
    n = pos + 30;
    run_seg(n);
    check("p100 no_valid_before", int'(rec_v[114]), 0);
    check("p100 first_valid", int'(rec_v[115]), 1);
    check("p100 second_valid", int'(rec_v[215]), 1);

    // Held high after one rise: timeout, then recovery needs two rises.
    clear_stim();
    for (int i = 4; i < 1300; i++) v[i] = 1'b1;
    pos = 1310;
    add_pwm(pos, 20, 5, 3);
    n = pos + 30;
    run_seg(n);
    run_model(n);
    compare_model(n, "hold_hi");
    check("hold_hi stuck_before", int'(rec_s[1029]), 0);
    check("hold_hi stuck", int'(rec_s[1030]), 1);
    check("hold_hi valid", int'(rec_v[1030]), 1);
    check("hold_hi duty", rec_d[1030], 100);
    check("hold_hi period", rec_p[1030], 0);
    check("hold_hi high", rec_h[1030], 0);
    check("hold_hi single_valid", int'(rec_v[1031]), 0);
    check("hold_hi stuck_clear", int'(rec_s[1313]), 0);
    check("hold_hi no_valid_first_edge", int'(rec_v[1321]), 0);
    check("hold_hi resume_valid", int'(rec_v[1341]), 1);
    check("hold_hi resume_duty", rec_d[1341], 25);

    // Held low after one short pulse.
    clear_stim();
    v[4] = 1'b1;
    n = 1100;
    run_seg(n);
    run_model(n);
    compare_model(n, "hold_lo");
    check("hold_lo stuck", int'(rec_s[1030]), 1);
    check("hold_lo valid", int'(rec_v[1030]), 1);
    check("hold_lo duty", rec_d[1030], 0);

    // No edge at all after reset.
    clear_stim();
    n = 1100;
    run_seg(n);
    run_model(n);
    compare_model(n, "idle");
    check("idle reset_duty", rec_d[0], 0);
    check("idle stuck_before", int'(rec_s[1023]), 0);
    check("idle stuck", int'(rec_s[1024]), 1);
    check("idle valid", int'(rec_v[1024]), 1);

    // Reset at the 4th iteration of the second divide (capture at 206).
    clear_stim();
    pos = 4;
    add_pwm(pos, 100, 3, 5);
    n = pos + 30;
    rv[210] = 1'b1;
    run_seg(n);
    run_model(n);
    compare_model(n, "rst_div");
    check("rst_div pre_valid", int'(rec_v[115]), 1);
    check("rst_div pre_duty", rec_d[115], 3);
    check("rst_div zero_duty", rec_d[211], 0);
    check("rst_div zero_period", rec_p[211], 0);
    check("rst_div zero_high", rec_h[211], 0);
    check("rst_div aborted", int'(rec_v[215]), 0);
    check("rst_div first_edge", int'(rec_v[315]), 0);
    check("rst_div resume", int'(rec_v[415]), 1);
    check("rst_div resume_period", rec_p[415], 100);
    check("rst_div resume_high", rec_h[415], 3);

    // Randomized waveforms with per-period jitter and occasional mid-run reset.
    for (int seg = 0; seg < 6; seg++) begin
      clear_stim();
      pos = $urandom_range(0, 10);
      while (pos < 1400) begin
        per = $urandom_range(2, 40);
        hi  = $urandom_range(1, per - 1);
        add_pwm(pos, per, hi, 1);
      end
      n = pos + 30;
      if (seg % 2 == 1) rv[$urandom_range(100, 1300)] = 1'b1;
      run_seg(n);
      run_model(n);
      compare_model(n, $sformatf("rnd%0d", seg));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Measures an incoming PWM waveform and reports its period, high time and duty cycle in percent (0-100).
It sits directly downstream of the PWM generator: it consumes PWM_OUT and closes the loop for self-check and on-board monitoring.
Measurement is rising-edge to rising-edge in the clk domain. The percent value comes from a multi-cycle shift-subtract divider.

Parameters:
CNT_W, 16, width of the period/high counters and of PERIOD_OUT/HIGH_OUT; also sets the stuck timeout of 2^CNT_W-1 cycles.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
PWM_IN  input  1  PWM waveform to measure, asynchronous to clk
DUTY_OUT  output  8  floor(100*HIGH/PERIOD), range 0..100
PERIOD_OUT  output  CNT_W  last measured period in clk cycles
HIGH_OUT  output  CNT_W  last measured high time in clk cycles
VALID  output  1  one-cycle pulse when the three outputs above update
STUCK  output  1  level; no rising edge seen for 2^CNT_W-1 cycles

Behaviour:
- Reset: one clk, synchronous, active-high; polarity and synchronicity fixed.
  - All outputs go to 0. Synchronizer, edge register, counters and divider clear. Measurement FSM returns to IDLE.
  - Reset asserted mid-divide aborts the division with no VALID.
- Input path:
  - 2-flop synchronizer, reset to 0, giving s.
  - Edge register s_d; rise = s & ~s_d.
  - PWM_IN rise to rise-pulse latency is 3 clk edges.
- Measurement FSM (IDLE, MEASURE):
  - IDLE: wait for rise. On rise, set period_cnt=1 and high_cnt=1, go to MEASURE. No capture on this first edge.
  - MEASURE, each cycle without rise: period_cnt+1; high_cnt+1 if s=1. Both saturate at 2^CNT_W-1.
  - MEASURE on rise (capture):
    - If the divider is idle, snapshot P=period_cnt, H=high_cnt and start the divider.
    - If the divider is busy, drop the sample silently.
    - Either way, restart the counters at 1 and stay in MEASURE.
  - Guarantees: P >= 2 (an edge needs a low cycle) and H <= P-1, so DUTY_OUT <= 99 for any real waveform.
- Divider:
  - Numerator N = 100*H, width CNT_W+7. Quotient is 8 bits; N < 256*P always holds.
  - Restoring scheme, one quotient bit per cycle, MSB first, 8 iterations. Bit k: if R >= P<<k, then R -= P<<k and q[k]=1. R starts at N.
  - Timing: capture at cycle t (loads operands); iterations run t+1..t+8.
  - At t+9: DUTY_OUT=q, PERIOD_OUT=P, HIGH_OUT=H update together and VALID=1 for that cycle only.
  - Busy spans t+1..t+9. A rise at t+10 is accepted.
  - Result is floor, never rounded up.
  - Outputs hold their value between VALID pulses.
- Stuck detection:
  - If period_cnt reaches 2^CNT_W-1 in MEASURE, or no rise for 2^CNT_W-1 cycles in IDLE after reset:
    - STUCK=1 and FSM goes to IDLE.
    - One VALID pulse (if the divider is idle) with DUTY_OUT=100 if s=1 else 0, PERIOD_OUT=0, HIGH_OUT=0.
  - STUCK stays 1 until the next rise, clearing in the rise cycle. That rise is treated as a first edge (no capture).
- Simultaneous events:
  - reset has priority over everything.
  - A rise in the same cycle as the stuck timeout counts as the rise; STUCK is not set.
  - A capture in the cycle VALID is asserted (t+9) is dropped, because the divider is still busy.

Test Plan:
- Reset, then PWM_IN period 100 / high 30, run 5 periods: first VALID after the 2nd rise+9 cycles, then one per period, each with DUTY_OUT=30, PERIOD_OUT=100, HIGH_OUT=30.
- Period 50 / high 26 (generator driven with DUTY_CYCLE=50): DUTY_OUT=52, PERIOD_OUT=50, HIGH_OUT=26. Period 3 / high 1: DUTY_OUT=33 (floor check).
- Period 5 / high 2: VALID exactly every 10 cycles, DUTY_OUT=40; alternate captures dropped, no corruption.
- CNT_W=10, PWM_IN held high after one rise: STUCK=1 at 1023 cycles, one VALID with DUTY_OUT=100, PERIOD_OUT=0. Next rise clears STUCK; VALID resumes only after the following rise.
- Same with PWM_IN held low: DUTY_OUT=0, STUCK=1.
- Assert reset at iteration 4 of a divide: no VALID; all outputs read 0 the cycle after reset; first VALID after reset requires two rises.
